// File: rtl/inst_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_queue_pkg
//   Shared widths, queue sizing defaults and the stored entry type for the
//   instruction queue that sits between instruction fetch and the decoder.
//   IQ_ID_WIDTH / IQ_ADDR_WIDTH : instruction word and pc widths
//   IQ_DEPTH / IQ_SLACK         : default queue depth and almost-full margin
//   iq_entry_t                  : one buffered {inst, pc} pair
// ---------------------------------------------------------------------------
package inst_queue_pkg;

    localparam int IQ_ID_WIDTH   = 32;
    localparam int IQ_ADDR_WIDTH = 32;
    localparam int IQ_DEPTH      = 16;
    localparam int IQ_SLACK      = 2;

    typedef struct packed {
        logic [IQ_ID_WIDTH-1:0]   inst;
        logic [IQ_ADDR_WIDTH-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_ram.sv
// ---------------------------------------------------------------------------
// iq_ram
//   Storage array for the instruction queue: DEPTH entries of iq_entry_t,
//   one synchronous write port and one asynchronous read port. Contents are
//   not reset; occupancy tracking in the parent decides what is valid.
//   Ports:
//     clk_in      : clock
//     wr_en_in    : write strobe
//     wr_addr_in  : write index
//     wr_data_in  : entry to store
//     rd_addr_in  : read index
//     rd_data_out : entry at rd_addr_in (combinational)
// ---------------------------------------------------------------------------
module iq_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_in,
    input  logic          wr_en_in,
    input  logic [AW-1:0] wr_addr_in,
    input  iq_entry_t     wr_data_in,
    input  logic [AW-1:0] rd_addr_in,
    output iq_entry_t     rd_data_out
);

    iq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            mem_q[wr_addr_in] <= wr_data_in;
        end
    end

    // Head entry must be visible in the same cycle the count becomes non-zero.
    assign rd_data_out = mem_q[rd_addr_in];

endmodule

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Instruction FIFO between fetch and decode. Buffers fetched {inst, pc}
//   pairs, presents the oldest to the decoder, flushes on a JAL redirect or a
//   ROB mispredict flush, and raises almost-full early so fetch can stop
//   while its in-flight requests still have room.
//   Ports:
//     clk_in, rst_n_in               : clock, async active-low reset
//     rdy_in                         : global ready, low freezes all state
//     if_instqueue_en_in/_inst_in/_pc_in : push from fetch
//     instqueue_if_full_out          : almost-full back-pressure to fetch
//     instqueue_decoder_en_out/_inst_out/_pc_out : head entry to decoder
//     decoder_instqueue_rdy_in       : decoder consumes head
//     decoder_instqueue_rst_in       : flush (JAL redirect)
//     rob_instqueue_rst_in           : flush (mispredict / exception)
//     instqueue_overflow_out         : sticky, push seen while completely full
// ---------------------------------------------------------------------------
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int SLACK = IQ_SLACK
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     if_instqueue_en_in,
    input  logic [IQ_ID_WIDTH-1:0]   if_instqueue_inst_in,
    input  logic [IQ_ADDR_WIDTH-1:0] if_instqueue_pc_in,
    output logic                     instqueue_if_full_out,
    output logic                     instqueue_decoder_en_out,
    output logic [IQ_ID_WIDTH-1:0]   instqueue_decoder_inst_out,
    output logic [IQ_ADDR_WIDTH-1:0] instqueue_decoder_pc_out,
    input  logic                     decoder_instqueue_rdy_in,
    input  logic                     decoder_instqueue_rst_in,
    input  logic                     rob_instqueue_rst_in,
    output logic                     instqueue_overflow_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - SLACK);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic      flush;
    logic      has_room;
    logic      push;
    logic      pop;
    logic      wr_en;
    iq_entry_t wr_entry;
    iq_entry_t head_entry;

    assign flush    = decoder_instqueue_rst_in | rob_instqueue_rst_in;
    assign has_room = (count_q != DEPTH_CNT);
    assign push     = if_instqueue_en_in & has_room;
    assign pop      = (count_q != '0) & decoder_instqueue_rdy_in;
    // Storage is only written when the push actually commits.
    assign wr_en    = rdy_in & ~flush & push;

    assign wr_entry.inst = if_instqueue_inst_in;
    assign wr_entry.pc   = if_instqueue_pc_in;

    iq_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk_in      (clk_in),
        .wr_en_in    (wr_en),
        .wr_addr_in  (tail_q),
        .wr_data_in  (wr_entry),
        .rd_addr_in  (head_q),
        .rd_data_out (head_entry)
    );

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (rdy_in) begin
            if (flush) begin
                // Flush wins over same-cycle push/pop; overflow is kept.
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    tail_d = tail_q + PTR_W'(1);
                end
                if (pop) begin
                    head_d = head_q + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
                // Judged on the pre-pop count: a pop in the same cycle does
                // not rescue a push that arrived while completely full.
                if (if_instqueue_en_in && !has_room) begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign instqueue_decoder_en_out   = (count_q != '0);
    assign instqueue_decoder_inst_out = head_entry.inst;
    assign instqueue_decoder_pc_out   = head_entry.pc;
    assign instqueue_if_full_out      = (count_q >= AFULL_CNT);
    assign instqueue_overflow_out     = overflow_q;

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
//   Scoreboard bench for inst_queue. The driver applies each cycle's inputs
//   and updates a queue-based reference model; a monitor on the falling edge
//   checks occupancy-derived outputs and pops the expected entry whenever
//   the decoder consumes the head.
// ---------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int SLACK = 2;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        if_en;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        full_out;
    logic        dec_en_out;
    logic [31:0] dec_inst_out;
    logic [31:0] dec_pc_out;
    logic        dec_rdy;
    logic        dec_rst;
    logic        rob_rst;
    logic        ovf_out;

    inst_queue #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk_in                     (clk_in),
        .rst_n_in                   (rst_n_in),
        .rdy_in                     (rdy_in),
        .if_instqueue_en_in         (if_en),
        .if_instqueue_inst_in       (if_inst),
        .if_instqueue_pc_in         (if_pc),
        .instqueue_if_full_out      (full_out),
        .instqueue_decoder_en_out   (dec_en_out),
        .instqueue_decoder_inst_out (dec_inst_out),
        .instqueue_decoder_pc_out   (dec_pc_out),
        .decoder_instqueue_rdy_in   (dec_rdy),
        .decoder_instqueue_rst_in   (dec_rst),
        .rob_instqueue_rst_in       (rob_rst),
        .instqueue_overflow_out     (ovf_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: contents in FIFO order as {inst, pc}, plus sticky flag.
    logic [63:0] exp_q[$];
    logic        model_ovf = 1'b0;
    logic        pop_seen  = 1'b0;
    int          checks    = 0;
    int          passed    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    endtask

    // Apply the inputs that were sampled at the edge just passed to the model.
    task automatic model_apply();
        int pre;
        if (rst_n_in && rdy_in) begin
            if (dec_rst || rob_rst) begin
                exp_q.delete();
            end else begin
                pre = exp_q.size() + (pop_seen ? 1 : 0);
                if (if_en) begin
                    if (pre < DEPTH) exp_q.push_back({if_inst, if_pc});
                    else             model_ovf = 1'b1;
                end
            end
        end
        pop_seen = 1'b0;
    endtask

    task automatic step(input logic p, input logic [31:0] ins, input logic [31:0] pcv,
                        input logic drdy, input logic drst, input logic rrst, input logic grdy);
        if_en   = p;
        if_inst = ins;
        if_pc   = pcv;
        dec_rdy = drdy;
        dec_rst = drst;
        rob_rst = rrst;
        rdy_in  = grdy;
        @(posedge clk_in);
        #2;
        model_apply();
    endtask

    task automatic push_only(input int n);
        for (int i = 0; i < n; i++) step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        #1;
        chk("rst_en", {63'h0, dec_en_out}, 64'h0);
        chk("rst_full", {63'h0, full_out}, 64'h0);
        chk("rst_ovf", {63'h0, ovf_out}, 64'h0);
        exp_q.delete();
        model_ovf = 1'b0;
        pop_seen  = 1'b0;
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
    endtask

    // Monitor: outputs settle well before the falling edge.
    always @(negedge clk_in) begin
        logic [63:0] e;
        if (rst_n_in) begin
            chk("en", {63'h0, dec_en_out}, {63'h0, exp_q.size() != 0});
            chk("full", {63'h0, full_out}, {63'h0, exp_q.size() >= DEPTH - SLACK});
            chk("ovf", {63'h0, ovf_out}, {63'h0, model_ovf});
            chk("count", 64'(dut.count_q), 64'(exp_q.size()));
            if (rdy_in && !dec_rst && !rob_rst && dec_rdy && dec_en_out && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("inst", {32'h0, dec_inst_out}, {32'h0, e[63:32]});
                chk("pc", {32'h0, dec_pc_out}, {32'h0, e[31:0]});
                pop_seen = 1'b1;
            end
        end
    end

    initial begin
        rst_n_in = 1'b1;
        rdy_in   = 1'b1;
        if_en    = 1'b0;
        if_inst  = '0;
        if_pc    = '0;
        dec_rdy  = 1'b0;
        dec_rst  = 1'b0;
        rob_rst  = 1'b0;
        #1;

        // Reset held with push asserted.
        if_en = 1'b1;
        rst_n_in = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        chk("reset_en", {63'h0, dec_en_out}, 64'h0);
        chk("reset_full", {63'h0, full_out}, 64'h0);
        chk("reset_ovf", {63'h0, ovf_out}, 64'h0);
        if_en = 1'b0;
        rst_n_in = 1'b1;

        // Ordered delivery of three instructions.
        step(1'b1, 32'h00000013, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h00100093, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h00200113, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
        drain(3);
        chk("order_empty", {63'h0, dec_en_out}, 64'h0);

        // Fill to almost-full, full, then overflow.
        push_only(13);
        chk("fill13_full", {63'h0, full_out}, 64'h0);
        push_only(1);
        chk("fill14_full", {63'h0, full_out}, 64'h1);
        push_only(2);
        chk("fill16_ovf", {63'h0, ovf_out}, 64'h0);
        push_only(1);
        chk("fill17_ovf", {63'h0, ovf_out}, 64'h1);
        chk("fill17_count", 64'(dut.count_q), 64'd16);
        drain(17);

        // Simultaneous push+pop at count 5, across pointer wrap.
        push_only(5);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pp_count", 64'(dut.count_q), 64'd5);
        drain(6);

        // Decoder flush with push and pop in the same cycle.
        push_only(8);
        step(1'b1, 32'hDEADBEEF, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush_en", {63'h0, dec_en_out}, 64'h0);
        chk("flush_count", 64'(dut.count_q), 64'd0);
        step(1'b1, 32'h00300193, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
        drain(2);

        // Freeze with push, pop and ROB flush requested.
        push_only(4);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("freeze_count", 64'(dut.count_q), 64'd4);
        chk("freeze_head", {32'h0, dec_inst_out}, {32'h0, exp_q[0][63:32]});
        drain(5);

        // Randomized traffic with occasional flushes, freezes and resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 65, $urandom, $urandom,
                     $urandom_range(0, 99) < 45,
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 90);
            end
        end
        drain(DEPTH + 1);
        chk("final_empty", {63'h0, dec_en_out}, 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
